// File: rtl/fetch_sequencer.sv
// Program-counter controller for a combinational-read instruction memory.
// It walks one of three resident program images and redirects on branch or
// jump. It stops on a halt opcode or on a fetch beyond the populated memory,
// and counts every instruction handed to the datapath.
module fetch_sequencer #(
    parameter logic [9:0] PROG0_BASE  = 10'd0,
    parameter logic [9:0] PROG1_BASE  = 10'd11,
    parameter logic [9:0] PROG2_BASE  = 10'd23,
    parameter logic [9:0] MAX_ADDR    = 10'd80,
    parameter logic [5:0] JUMP_OPCODE = 6'b010000,
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  program_sel,
    input  logic        abort,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    input  logic [31:0] instrucao,
    output logic [9:0]  address,
    output logic        instr_valid,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t state;

    logic [5:0]  opcode;
    logic        is_halt;
    logic        is_jump;
    logic [10:0] seq_addr;
    logic [10:0] next_addr;
    logic        out_of_range;
    logic        unused_bits;

    // Program image start address; code 3 falls back to program 0.
    function automatic logic [9:0] base_for(input logic [1:0] sel);
        case (sel)
            2'd1:    return PROG1_BASE;
            2'd2:    return PROG2_BASE;
            default: return PROG0_BASE;
        endcase
    endfunction

    // Retired counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    assign opcode      = instrucao[31:26];
    assign is_halt     = (opcode == HALT_OPCODE);
    assign is_jump     = (opcode == JUMP_OPCODE);
    assign unused_bits = ^instrucao[25:10];

    // Candidate next address, one bit wider so a +1 past 1023 is still seen as out of range.
    always_comb begin
        seq_addr = {1'b0, address} + 11'd1;
        if (branch_taken)
            next_addr = {1'b0, branch_target};
        else if (is_jump)
            next_addr = {1'b0, instrucao[9:0]};
        else
            next_addr = seq_addr;
        out_of_range = (next_addr > {1'b0, MAX_ADDR});
    end

    // Flags are pure decodes of the state register; only stall reaches instr_valid directly.
    assign instr_valid = (state == RUN) && !stall;
    assign busy        = (state == RUN);
    assign halted      = (state == HALT);
    assign fault       = (state == FAULT);

    // Sequencer: abort first, then per-state handling of start and the RUN redirect rules.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            address <= '0;
            retired <= '0;
        end else if (abort) begin
            // An instruction presented in the aborting cycle was still consumed.
            state   <= IDLE;
            address <= '0;
            if (instr_valid)
                retired <= sat_inc(retired);
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        retired <= sat_inc(retired);
                        if (is_halt) begin
                            state <= HALT;
                        end else if (out_of_range) begin
                            state   <= FAULT;
                            address <= next_addr[9:0];
                        end else begin
                            address <= next_addr[9:0];
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state   <= RUN;
                        address <= base_for(program_sel);
                        retired <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter controller that sequences the instruction memory: it drives the 10-bit `address`, presents each returned `instrucao` to the datapath with a valid flag, and follows sequential, jump and branch flow. It selects one of three resident program images by start address, honours datapath stalls, and stops on a halt opcode or an out-of-range fetch. It sits between the instruction memory (combinational read) and the control unit.

## Interface
Parameters:
- `PROG0_BASE`, 0, start address of program 0
- `PROG1_BASE`, 11, start address of program 1
- `PROG2_BASE`, 23, start address of program 2
- `MAX_ADDR`, 80, highest populated memory word
- `JUMP_OPCODE`, 6'b010000, unconditional jump, target in `instrucao[9:0]`
- `HALT_OPCODE`, 6'b111111, stop fetching

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begin the program selected by `program_sel`
- `program_sel`  in  2  0/1/2 select `PROGx_BASE`; 3 = `PROG0_BASE`
- `abort`  in  1  synchronous return to IDLE
- `stall`  in  1  hold the current address; instruction not consumed
- `branch_taken`  in  1  datapath branch resolved taken this cycle
- `branch_target`  in  10  branch destination
- `instrucao`  in  32  word read from instruction memory at `address`
- `address`  out  10  registered fetch address
- `instr_valid`  out  1  `instrucao` is a live instruction this cycle
- `busy`  out  1  state is RUN
- `halted`  out  1  state is HALT
- `fault`  out  1  state is FAULT
- `retired`  out  16  count of consumed instructions

## Operation
- States: IDLE, RUN, HALT, FAULT. Encoding is free.
- `instr_valid` = (state==RUN) && !stall. An instruction is consumed when `instr_valid`=1.
- IDLE: `start` -> `address` <= selected base, `retired` <= 0, RUN.
- RUN, next-address priority evaluated every cycle. First applicable rule wins:
  1. `abort` -> IDLE, `address` <= 0.
  2. `stall` -> hold everything. `branch_taken` is ignored while stalled.
  3. `instrucao[31:26]`==`HALT_OPCODE` -> HALT, address held. The halt word counts as consumed.
  4. `branch_taken` -> `branch_target`.
  5. `instrucao[31:26]`==`JUMP_OPCODE` -> `instrucao[9:0]`.
  6. otherwise -> `address`+1.
- Range check: next address is computed 11 bits wide. If it is >`MAX_ADDR`, or sequential +1 overflows past 1023 -> FAULT, `address` <= the offending value truncated to 10 bits. The instruction was still consumed.
- Start while in RUN is ignored.
- HALT / FAULT: `start` -> restart as in IDLE (new base, `retired` cleared). `abort` -> IDLE. `abort` has priority over `start` in every state.
- `retired`: +1 per consumed instruction, saturates at 16'hFFFF, cleared only by start/reset.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE, `address`=0, `retired`=0. All flags are 0 (`instr_valid`, `busy`, `halted`, `fault`).
- Memory read is combinational: `instrucao` corresponds to the current `address` in the same cycle. Zero-latency fetch, one instruction per cycle when not stalled.
- `start` sampled at edge N -> `address`=base and `busy`=1 after edge N; first `instr_valid` in cycle N+1.
- Branch/jump: redirect visible on `address` one edge after the deciding cycle. There are no delay slots and no bubbles.
- Outputs `busy`, `halted`, `fault`, `instr_valid` are decoded from registered state (no input-to-flag paths except `stall` -> `instr_valid`).
- Reset asserted mid-RUN: immediate IDLE regardless of clock.

## Test plan
- Reset then `start`, `program_sel`=1, memory word 11..13 = plain ALU ops -> `address` sequence 11,12,13, `retired`=3 after three cycles.
- Jump: word 10 = 32'b010000_...000101 -> `address` 10 then 5. Same cycle with `branch_taken`=1, target 40 -> `address` 40 (branch wins).
- Stall two cycles at address 7 with `branch_taken`=1 -> `address` stays 7, `instr_valid`=0, `retired` unchanged. Stall released, branch low -> 8.
- Halt opcode at address 4 -> `halted`=1 next cycle, `address`=4, `instr_valid`=0. Later `start` with `program_sel`=2 -> `address`=23, `retired`=0.
- Fault: sequential run to 80 -> `fault`=1, `address`=81. Branch target 100 from RUN -> `fault`=1, `address`=100. `abort`+`start` same cycle -> IDLE, `address`=0.
- Saturation: preload run long enough for `retired` to reach 16'hFFFF -> holds at 16'hFFFF. `reset_n` pulsed mid-run -> all outputs zero asynchronously.
